// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: producer side of the operand-bypass interface.
// Keeps destination metadata for the instructions in EX, MEM and WB, drives
// the rd/regwrite/link signals the forwarding unit consumes, and detects the
// hazards bypassing cannot hide (load-use, ID-stage branch/jalr operands).
// A cache stall freezes every register in this block.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_stall,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_link,
    input  logic             id_branch,
    input  logic             flush_id,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic [4:0]       ex_rd,
    output logic [4:0]       mem_rd,
    output logic [4:0]       wb_rd,
    output logic             ex_regwrite,
    output logic             mem_regwrite,
    output logic             wb_regwrite,
    output logic             mem_link,
    output logic             wb_link,
    output logic [CNT_W-1:0] stall_cnt
);

    // Metadata carried by one shadow stage. A zero value is a bubble.
    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       link;
    } stage_t;

    // EX and MEM keep the full record; WB only needs what it drives out,
    // since nothing downstream looks at whether the WB instruction was a load.
    stage_t ex_s;
    stage_t mem_s;
    stage_t id_entry;

    logic ex_writes;
    logic mem_writes;
    logic match_ex;
    logic match_mem;
    logic id_live;
    logic hazard;
    logic advance;

    // Dependence detection against EX and MEM; x0 is never a real producer.
    always_comb begin
        ex_writes  = 1'b0;
        mem_writes = 1'b0;
        match_ex   = 1'b0;
        match_mem  = 1'b0;
        id_live    = 1'b0;
        hazard     = 1'b0;

        ex_writes  = ex_s.regwrite && (ex_s.rd != 5'd0);
        mem_writes = mem_s.regwrite && (mem_s.rd != 5'd0);

        match_ex  = ex_writes &&
                    ((id_use_rs1 && (ex_s.rd == id_rs1)) ||
                     (id_use_rs2 && (ex_s.rd == id_rs2)));
        match_mem = mem_writes &&
                    ((id_use_rs1 && (mem_s.rd == id_rs1)) ||
                     (id_use_rs2 && (mem_s.rd == id_rs2)));

        // A flushed ID instruction is dead, so it can never demand a stall.
        id_live = id_valid && !flush_id;

        if (id_live) begin
            hazard = (ex_s.memread && match_ex) ||
                     (id_branch && match_ex) ||
                     (id_branch && mem_s.memread && match_mem);
        end
    end

    // Pipeline control outputs and the record that would enter EX.
    always_comb begin
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        advance     = 1'b0;
        id_entry    = '0;

        advance     = !mem_stall;
        stall_if_id = mem_stall || hazard;
        bubble_ex   = hazard && !mem_stall;

        if (id_live && !hazard) begin
            id_entry.rd       = id_rd;
            id_entry.regwrite = id_regwrite;
            id_entry.memread  = id_memread;
            id_entry.link     = id_link;
        end
    end

    // Shadow pipeline: shift EX->MEM->WB on every non-frozen edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_s        <= '0;
            mem_s       <= '0;
            wb_rd       <= 5'd0;
            wb_regwrite <= 1'b0;
            wb_link     <= 1'b0;
        end else if (advance) begin
            wb_rd       <= mem_s.rd;
            wb_regwrite <= mem_s.regwrite;
            wb_link     <= mem_s.link;
            mem_s       <= ex_s;
            ex_s        <= id_entry;
        end
    end

    // Saturating count of cycles lost to true hazards (cache stalls excluded).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && !mem_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Forwarding-unit view of the shadow stages.
    always_comb begin
        ex_rd        = ex_s.rd;
        ex_regwrite  = ex_s.regwrite;
        mem_rd       = mem_s.rd;
        mem_regwrite = mem_s.regwrite;
        mem_link     = mem_s.link;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard bench for hazard_scoreboard.
// A second instance with a 3-bit counter exercises saturation.
module tb_hazard_scoreboard;

    localparam int S_STALL  = 0;
    localparam int S_BUBBLE = 1;
    localparam int S_EXRD   = 2;
    localparam int S_EXRW   = 3;
    localparam int S_MEMRD  = 4;
    localparam int S_MEMRW  = 5;
    localparam int S_WBRD   = 6;
    localparam int S_WBRW   = 7;
    localparam int S_MEMLK  = 8;
    localparam int S_WBLK   = 9;
    localparam int S_CNT    = 10;
    localparam int S_SAT    = 11;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_stall;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_link;
    logic        id_branch;
    logic        flush_id;

    logic        stall_if_id;
    logic        bubble_ex;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        ex_regwrite;
    logic        mem_regwrite;
    logic        wb_regwrite;
    logic        mem_link;
    logic        wb_link;
    logic [15:0] stall_cnt;

    logic        s_stall_if_id;
    logic        s_bubble_ex;
    logic [4:0]  s_ex_rd;
    logic [4:0]  s_mem_rd;
    logic [4:0]  s_wb_rd;
    logic        s_ex_regwrite;
    logic        s_mem_regwrite;
    logic        s_wb_regwrite;
    logic        s_mem_link;
    logic        s_wb_link;
    logic [2:0]  s_stall_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_link(id_link), .id_branch(id_branch),
        .flush_id(flush_id), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite), .mem_link(mem_link), .wb_link(wb_link),
        .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CNT_W(3)) sat_dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_link(id_link), .id_branch(id_branch),
        .flush_id(flush_id), .stall_if_id(s_stall_if_id), .bubble_ex(s_bubble_ex),
        .ex_rd(s_ex_rd), .mem_rd(s_mem_rd), .wb_rd(s_wb_rd),
        .ex_regwrite(s_ex_regwrite), .mem_regwrite(s_mem_regwrite),
        .wb_regwrite(s_wb_regwrite), .mem_link(s_mem_link), .wb_link(s_wb_link),
        .stall_cnt(s_stall_cnt)
    );

    function automatic logic [15:0] get_obs(input int sel);
        case (sel)
            S_STALL:  get_obs = {15'd0, stall_if_id};
            S_BUBBLE: get_obs = {15'd0, bubble_ex};
            S_EXRD:   get_obs = {11'd0, ex_rd};
            S_EXRW:   get_obs = {15'd0, ex_regwrite};
            S_MEMRD:  get_obs = {11'd0, mem_rd};
            S_MEMRW:  get_obs = {15'd0, mem_regwrite};
            S_WBRD:   get_obs = {11'd0, wb_rd};
            S_WBRW:   get_obs = {15'd0, wb_regwrite};
            S_MEMLK:  get_obs = {15'd0, mem_link};
            S_WBLK:   get_obs = {15'd0, wb_link};
            S_CNT:    get_obs = stall_cnt;
            S_SAT:    get_obs = {13'd0, s_stall_cnt};
            default:  get_obs = 16'hdead;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_all_zero(input string tag);
        for (int i = 0; i <= S_SAT; i++) push(tag, i, 16'd0);
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic lk,
                                 input logic br, input logic fl);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_link     = lk;
        id_branch   = br;
        flush_id    = fl;
    endtask

    task automatic nop();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lw5();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add6_use5(input logic fl);
        applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, fl);
    endtask

    // Pops every pending expectation and compares it with the DUT now.
    task automatic checkOutput(input bit wait_edge);
        exp_t e;
        logic [15:0] obs;
        if (wait_edge) @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_obs(e.sel);
            compared++;
            assert (obs === e.val) else begin
                mismatched++;
                $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One load-use pair: lw x5, then add x6,x5 stalls exactly once.
    task automatic load_use_pair(input logic [15:0] cnt_after, input logic [15:0] sat_after);
        lw5();
        push("pair_lw_nostall", S_STALL, 16'd0);
        checkOutput(1);
        next_cycle();
        add6_use5(1'b0);
        push("pair_stall", S_STALL, 16'd1);
        push("pair_bubble", S_BUBBLE, 16'd1);
        checkOutput(1);
        next_cycle();
        push("pair_release", S_STALL, 16'd0);
        push("pair_cnt", S_CNT, cnt_after);
        push("pair_sat", S_SAT, sat_after);
        checkOutput(1);
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        mem_stall = 1'b1;
        nop();
        #2;
        // Reset state; stall_if_id follows mem_stall while in reset.
        push("rst_stall_follows_mem", S_STALL, 16'd1);
        for (int i = 1; i <= S_SAT; i++) push("rst_zero", i, 16'd0);
        checkOutput(0);
        mem_stall = 1'b0;
        #1;
        push("rst_stall_off", S_STALL, 16'd0);
        checkOutput(0);
        rst = 1'b0;
        next_cycle();

        // Load-use: lw x5 ; add x6,x5,x1
        lw5();
        push("lu_lw_nostall", S_STALL, 16'd0);
        checkOutput(1);
        next_cycle();
        add6_use5(1'b0);
        push("lu_stall", S_STALL, 16'd1);
        push("lu_bubble", S_BUBBLE, 16'd1);
        push("lu_ex_rd", S_EXRD, 16'd5);
        checkOutput(1);
        next_cycle();
        push("lu_after_stall", S_STALL, 16'd0);
        push("lu_ex_rd_bubble", S_EXRD, 16'd0);
        push("lu_ex_rw_bubble", S_EXRW, 16'd0);
        push("lu_mem_rd", S_MEMRD, 16'd5);
        push("lu_mem_rw", S_MEMRW, 16'd1);
        push("lu_cnt", S_CNT, 16'd1);
        checkOutput(1);
        next_cycle();

        // lw x5 ; beq x5,x0 -> two stall cycles
        lw5();
        push("bl_lw_nostall", S_STALL, 16'd0);
        checkOutput(1);
        next_cycle();
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push("bl_stall1", S_STALL, 16'd1);
        push("bl_bubble1", S_BUBBLE, 16'd1);
        checkOutput(1);
        next_cycle();
        push("bl_stall2", S_STALL, 16'd1);
        push("bl_bubble2", S_BUBBLE, 16'd1);
        push("bl_mem_rd", S_MEMRD, 16'd5);
        checkOutput(1);
        next_cycle();
        push("bl_release", S_STALL, 16'd0);
        push("bl_wb_rd", S_WBRD, 16'd5);
        push("bl_cnt", S_CNT, 16'd3);
        checkOutput(1);
        next_cycle();

        // add x7 ; jalr x0,0(x7) -> one stall cycle
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("ba_add_nostall", S_STALL, 16'd0);
        checkOutput(1);
        next_cycle();
        applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        push("ba_stall", S_STALL, 16'd1);
        push("ba_bubble", S_BUBBLE, 16'd1);
        checkOutput(1);
        next_cycle();
        push("ba_release", S_STALL, 16'd0);
        push("ba_cnt", S_CNT, 16'd4);
        checkOutput(1);
        next_cycle();

        // jal x1 followed by nops: link travels MEM then WB
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        nop();
        push("jal_ex_rd", S_EXRD, 16'd1);
        checkOutput(1);
        next_cycle();
        push("jal_mem_link", S_MEMLK, 16'd1);
        push("jal_mem_rd", S_MEMRD, 16'd1);
        checkOutput(1);
        next_cycle();
        push("jal_wb_link", S_WBLK, 16'd1);
        push("jal_wb_rd", S_WBRD, 16'd1);
        push("jal_mem_link_gone", S_MEMLK, 16'd0);
        checkOutput(1);
        next_cycle();

        // lw x0 ; add x6,x0,x0 -> x0 never stalls
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("x0_nostall", S_STALL, 16'd0);
        push("x0_nobubble", S_BUBBLE, 16'd0);
        checkOutput(1);
        next_cycle();

        // Load-use pair with the consumer flushed
        lw5();
        next_cycle();
        add6_use5(1'b1);
        push("fl_nostall", S_STALL, 16'd0);
        push("fl_nobubble", S_BUBBLE, 16'd0);
        push("fl_cnt", S_CNT, 16'd4);
        checkOutput(1);
        next_cycle();
        nop();
        push("fl_killed_ex", S_EXRW, 16'd0);
        push("fl_mem_rd", S_MEMRD, 16'd5);
        checkOutput(1);
        next_cycle();

        // Load-use held by three frozen cycles, then one bubble
        lw5();
        next_cycle();
        add6_use5(1'b0);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("ms_stall", S_STALL, 16'd1);
            push("ms_nobubble", S_BUBBLE, 16'd0);
            push("ms_ex_held", S_EXRD, 16'd5);
            push("ms_wb_held", S_WBRD, 16'd0);
            push("ms_cnt_held", S_CNT, 16'd4);
            checkOutput(1);
            next_cycle();
        end
        mem_stall = 1'b0;
        push("ms_rel_stall", S_STALL, 16'd1);
        push("ms_rel_bubble", S_BUBBLE, 16'd1);
        checkOutput(1);
        next_cycle();
        push("ms_done", S_STALL, 16'd0);
        push("ms_ex_bubble", S_EXRD, 16'd0);
        push("ms_mem_rd", S_MEMRD, 16'd5);
        push("ms_cnt", S_CNT, 16'd5);
        checkOutput(1);
        next_cycle();

        // Reset asserted in the middle of a load-use stall
        lw5();
        next_cycle();
        add6_use5(1'b0);
        push("mr_stall", S_STALL, 16'd1);
        checkOutput(1);
        rst = 1'b1;
        #1;
        push_all_zero("mr_reset_zero");
        checkOutput(0);
        next_cycle();
        rst = 1'b0;
        push("mr_reeval_stall", S_STALL, 16'd0);
        push("mr_reeval_bubble", S_BUBBLE, 16'd0);
        checkOutput(1);
        next_cycle();

        // Counter saturation: 3-bit instance pinned at 7, 16-bit keeps counting
        for (int i = 1; i <= 6; i++) load_use_pair(16'(i), 16'(i));
        for (int i = 7; i <= 9; i++) load_use_pair(16'(i), 16'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
